hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline hazard controller for the five-stage core (IF/ID/EX/MEM/WB). Collects load-use flags from the two ID-stage operand bypass units, multi-cycle EX busy, LSU memory wait, EX branch redirect and WB exception. Generates per-stage stall/flush controls and a PC redirect select. Sequences multi-cycle load-use bubbles with a small FSM and keeps saturating stall/flush performance counters.

## Interface
- `LOAD_USE_BUBBLES`, 1: bubble cycles inserted per load-use hazard; legal range ≥1.
- `CNT_WIDTH`, 32: width of performance counters.

- `clk`  in  1  core clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_load_flag`  in  1  load-use hazard on operand 1 from its ID bypass unit.
- `rs2_load_flag`  in  1  load-use hazard on operand 2 from its ID bypass unit.
- `ex_busy`  in  1  multi-cycle EX op (div/mul) not finished; level.
- `mem_stall`  in  1  LSU waiting on bus; level.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `wb_excp`  in  1  exception/ertn committing in WB.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM register.
- `flush_id`, `flush_ex`, `flush_mem`, `flush_wb`  out  1 each  load bubble into IF-ID / ID-EX / EX-MEM / MEM-WB register.
- `redirect_sel`  out  2  00 none, 01 branch target, 10 exception entry.
- `hazard_state`  out  1  0 RUN, 1 BUBBLE (debug).
- `stall_cnt`  out  CNT_WIDTH  cycles with stall_if=1.
- `flush_cnt`  out  CNT_WIDTH  cycles with redirect_sel≠00.

## Operation
- FSM states: RUN, BUBBLE. Down-counter `bub_left` of width $clog2(LOAD_USE_BUBBLES+1).
- Outputs are combinational from state and inputs, evaluated in strict priority:
  1. `rst`: all flush_*=1, all stall_*=0, redirect_sel=00.
  2. `wb_excp`: flush_id/ex/mem/wb=1, stalls 0, redirect_sel=10. Next state RUN; `bub_left` cleared.
  3. `mem_stall`: stall_if/id/ex/mem=1, flush_wb=1. FSM and `bub_left` frozen. A simultaneous branch is ignored; it reasserts after the stall.
  4. `ex_busy`: stall_if/id/ex=1, flush_mem=1. FSM frozen.
  5. `ex_branch_taken`: flush_id=1, flush_ex=1, redirect_sel=01. Next state RUN, overriding any load-use; the younger consumer is squashed.
  6. Load-use, i.e. (rs1_load_flag|rs2_load_flag) in RUN, or state BUBBLE: stall_if=1, stall_id=1, flush_ex=1.
  7. Otherwise all outputs 0.
- In RUN, a load-use entering case 6:
  - LOAD_USE_BUBBLES==1: stay RUN.
  - Otherwise: go to BUBBLE with `bub_left`=LOAD_USE_BUBBLES−1.
- In BUBBLE, on each unfrozen cycle: `bub_left` decrements. Leave for RUN on the cycle it holds 1. The load_flag inputs are ignored while in BUBBLE.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones (no wrap). Neither counts while `rst`=1.

## Timing
- Zero-cycle latency: hazard inputs in cycle t drive stalls/flushes in cycle t.
- A load-use hazard costs exactly LOAD_USE_BUBBLES cycles of stall_if/stall_id, excluding frozen cycles.
- FSM, `bub_left` and counters update on rising `clk`.
- Reset values: state RUN, `bub_left` 0, `stall_cnt` 0, `flush_cnt` 0, `hazard_state` 0.
- `rst` asserted mid-BUBBLE returns the FSM to RUN on the next edge.
- Freeze cycles (mem_stall/ex_busy) neither advance nor restart a bubble sequence.
- Exception in any state ends the sequence immediately.

## Test plan
- LOAD_USE_BUBBLES=1, rs1_load_flag=1 for one cycle → stall_if=stall_id=flush_ex=1 that cycle only; stall_cnt 0→1; state stays RUN.
- LOAD_USE_BUBBLES=3, rs2_load_flag pulse at t → stall_if=1 for t, t+1, t+2; hazard_state=1 at t+1, t+2; RUN at t+3; stall_cnt=3.
- LOAD_USE_BUBBLES=3, mem_stall=1 at t+1 for 2 cycles → all four stalls high t+1..t+2; bubble resumes and ends after t+4; stall_cnt=5.
- ex_branch_taken with rs1_load_flag same cycle → flush_id=flush_ex=1, redirect_sel=01, no stall; flush_cnt=1.
- wb_excp with mem_stall and ex_branch_taken same cycle → all flushes 1, no stalls, redirect_sel=10, state RUN.
- Preload stall_cnt to all-ones via forcing, hold ex_busy → counter stays all-ones. Then rst=1 → all flush_*=1, counters 0 next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority-encodes hazard sources into per-stage stall/flush
// controls, sequences multi-cycle load-use bubbles and keeps saturating stall/flush counters.
module hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs1_load_flag,
  input  logic                 rs2_load_flag,
  input  logic                 ex_busy,
  input  logic                 mem_stall,
  input  logic                 ex_branch_taken,
  input  logic                 wb_excp,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_mem,
  output logic                 flush_wb,
  output logic [1:0]           redirect_sel,
  output logic                 hazard_state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int BW = $clog2(LOAD_USE_BUBBLES + 1);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t              state_reg;
  logic [BW-1:0]       bub_left_reg;
  logic                load_use;
  logic [1:0]          cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_reg [2];

  assign load_use     = rs1_load_flag | rs2_load_flag;
  assign hazard_state = state_reg;

  // Strict priority: reset > exception > mem wait > EX busy > branch > load-use.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    flush_mem    = 1'b0;
    flush_wb     = 1'b0;
    redirect_sel = 2'b00;
    if (rst) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (wb_excp) begin
      flush_id     = 1'b1;
      flush_ex     = 1'b1;
      flush_mem    = 1'b1;
      flush_wb     = 1'b1;
      redirect_sel = 2'b10;
    end else if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (ex_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id     = 1'b1;
      flush_ex     = 1'b1;
      redirect_sel = 2'b01;
    end else if (load_use || state_reg == BUBBLE) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      bub_left_reg <= '0;
    end else if (wb_excp || (ex_branch_taken && !mem_stall && !ex_busy)) begin
      state_reg    <= RUN;
      bub_left_reg <= '0;
    end else if (!mem_stall && !ex_busy) begin
      if (state_reg == BUBBLE) begin
        // Load flags are ignored here; the bubble runs out its count.
        if (bub_left_reg == BW'(1)) begin
          state_reg    <= RUN;
          bub_left_reg <= '0;
        end else begin
          bub_left_reg <= bub_left_reg - 1'b1;
        end
      end else if (load_use && LOAD_USE_BUBBLES > 1) begin
        state_reg    <= BUBBLE;
        bub_left_reg <= BW'(LOAD_USE_BUBBLES - 1);
      end
    end
  end

  assign cnt_inc = {redirect_sel != 2'b00, stall_if};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && cnt_reg[gi] != '1) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1-bubble with 4-bit counters, 3-bubble)
// driven by directed vectors; a negedge monitor pops expected responses and compares.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Input packing: {rst, rs1, rs2, ex_busy, mem_stall, branch, excp}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_RS1  = 7'b0100000;
  localparam logic [6:0] I_RS2  = 7'b0010000;
  localparam logic [6:0] I_BUSY = 7'b0001000;
  localparam logic [6:0] I_MEM  = 7'b0000100;
  localparam logic [6:0] I_BR   = 7'b0000010;
  localparam logic [6:0] I_EXC  = 7'b0000001;

  // Control packing: {stall if/id/ex/mem, flush id/ex/mem/wb, redirect_sel, hazard_state}
  localparam logic [10:0] C_IDLE = 11'b0000_0000_00_0;
  localparam logic [10:0] C_RST  = 11'b0000_1111_00_0;
  localparam logic [10:0] C_LU   = 11'b1100_0100_00_0;
  localparam logic [10:0] C_LUB  = 11'b1100_0100_00_1;
  localparam logic [10:0] C_MEM  = 11'b1111_0001_00_0;
  localparam logic [10:0] C_MEMB = 11'b1111_0001_00_1;
  localparam logic [10:0] C_BUSY = 11'b1110_0010_00_0;
  localparam logic [10:0] C_BUSB = 11'b1110_0010_00_1;
  localparam logic [10:0] C_BR   = 11'b0000_1100_01_0;
  localparam logic [10:0] C_BRB  = 11'b0000_1100_01_1;
  localparam logic [10:0] C_EXC  = 11'b0000_1111_10_0;
  localparam logic [10:0] C_EXCB = 11'b0000_1111_10_1;
  localparam logic [10:0] C_RSTB = 11'b0000_1111_00_1;

  logic [6:0]  in_a, in_b;
  logic [10:0] ctrl_a, ctrl_b;
  logic [3:0]  scnt_a, fcnt_a;
  logic [31:0] scnt_b, fcnt_b;

  logic a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_fmem, a_fwb, a_st;
  logic b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_fmem, b_fwb, b_st;
  logic [1:0] a_red, b_red;

  hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_WIDTH(4)) u_lub1 (
    .clk(clk), .rst(in_a[6]), .rs1_load_flag(in_a[5]), .rs2_load_flag(in_a[4]),
    .ex_busy(in_a[3]), .mem_stall(in_a[2]), .ex_branch_taken(in_a[1]), .wb_excp(in_a[0]),
    .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex), .stall_mem(a_smem),
    .flush_id(a_fid), .flush_ex(a_fex), .flush_mem(a_fmem), .flush_wb(a_fwb),
    .redirect_sel(a_red), .hazard_state(a_st), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_WIDTH(32)) u_lub3 (
    .clk(clk), .rst(in_b[6]), .rs1_load_flag(in_b[5]), .rs2_load_flag(in_b[4]),
    .ex_busy(in_b[3]), .mem_stall(in_b[2]), .ex_branch_taken(in_b[1]), .wb_excp(in_b[0]),
    .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex), .stall_mem(b_smem),
    .flush_id(b_fid), .flush_ex(b_fex), .flush_mem(b_fmem), .flush_wb(b_fwb),
    .redirect_sel(b_red), .hazard_state(b_st), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  assign ctrl_a = {a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_fmem, a_fwb, a_red, a_st};
  assign ctrl_b = {b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_fmem, b_fwb, b_red, b_st};

  typedef struct packed {
    logic        which;
    logic [10:0] ctrl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;
  logic [10:0] act_ctrl;
  logic [31:0] act_sc, act_fc;

  // Monitor: every cycle is an output cycle; compare mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon    = q.pop_front();
      act_ctrl = e_mon.which ? ctrl_b : ctrl_a;
      act_sc   = e_mon.which ? scnt_b : {28'd0, scnt_a};
      act_fc   = e_mon.which ? fcnt_b : {28'd0, fcnt_a};
      $display("txn %0d dut%0d ctrl=%b stall_cnt=%0d flush_cnt=%0d", txn,
               e_mon.which ? 3 : 1, act_ctrl, act_sc, act_fc);
      n_checks += 3;
      if (act_ctrl !== e_mon.ctrl) begin
        n_fail++;
        $display("FAIL txn %0d ctrl: got %b expected %b", txn, act_ctrl, e_mon.ctrl);
      end
      if (act_sc !== e_mon.sc) begin
        n_fail++;
        $display("FAIL txn %0d stall_cnt: got %0d expected %0d", txn, act_sc, e_mon.sc);
      end
      if (act_fc !== e_mon.fc) begin
        n_fail++;
        $display("FAIL txn %0d flush_cnt: got %0d expected %0d", txn, act_fc, e_mon.fc);
      end
      txn++;
    end
  end

  task automatic step(input logic which, input logic [6:0] in, input logic [10:0] c,
                      input int sc, input int fc);
    @(posedge clk);
    #1;
    if (which) begin
      in_b = in;
      in_a = I_NONE;
    end else begin
      in_a = in;
      in_b = I_NONE;
    end
    q.push_back('{which: which, ctrl: c, sc: 32'(sc), fc: 32'(fc)});
  endtask

  initial begin
    in_a = I_RST;
    in_b = I_RST;

    // LOAD_USE_BUBBLES=1 instance
    step(0, I_RST,               C_RST,  0, 0);
    step(0, I_NONE,              C_IDLE, 0, 0);
    step(0, I_RS1,               C_LU,   0, 0);
    step(0, I_NONE,              C_IDLE, 1, 0);
    step(0, I_BR | I_RS1,        C_BR,   1, 0);
    step(0, I_NONE,              C_IDLE, 1, 1);
    step(0, I_EXC | I_MEM | I_BR, C_EXC, 1, 1);
    step(0, I_NONE,              C_IDLE, 1, 2);
    step(0, I_MEM | I_BR,        C_MEM,  1, 2);
    step(0, I_BUSY | I_BR,       C_BUSY, 2, 2);
    // 4-bit stall counter saturates at 15 while ex_busy is held
    for (int k = 0; k < 14; k++) begin
      step(0, I_BUSY, C_BUSY, (3 + k > 15) ? 15 : 3 + k, 2);
    end
    step(0, I_RST,               C_RST,  15, 2);
    step(0, I_NONE,              C_IDLE, 0, 0);

    // LOAD_USE_BUBBLES=3 instance: plain bubble, rs1 ignored mid-bubble
    step(1, I_RST,  C_RST,  0, 0);
    step(1, I_NONE, C_IDLE, 0, 0);
    step(1, I_RS2,  C_LU,   0, 0);
    step(1, I_NONE, C_LUB,  1, 0);
    step(1, I_RS1,  C_LUB,  2, 0);
    step(1, I_NONE, C_IDLE, 3, 0);
    // bubble frozen by two mem_stall cycles
    step(1, I_RS1,  C_LU,   3, 0);
    step(1, I_MEM,  C_MEMB, 4, 0);
    step(1, I_MEM,  C_MEMB, 5, 0);
    step(1, I_NONE, C_LUB,  6, 0);
    step(1, I_NONE, C_LUB,  7, 0);
    step(1, I_NONE, C_IDLE, 8, 0);
    // exception ends bubble
    step(1, I_RS1,  C_LU,   8, 0);
    step(1, I_EXC,  C_EXCB, 9, 0);
    step(1, I_NONE, C_IDLE, 9, 1);
    // branch ends bubble
    step(1, I_RS2,  C_LU,   9, 1);
    step(1, I_BR,   C_BRB,  10, 1);
    step(1, I_NONE, C_IDLE, 10, 2);
    // ex_busy freezes bubble
    step(1, I_RS1,  C_LU,   10, 2);
    step(1, I_BUSY, C_BUSB, 11, 2);
    step(1, I_NONE, C_LUB,  12, 2);
    step(1, I_NONE, C_LUB,  13, 2);
    step(1, I_NONE, C_IDLE, 14, 2);
    // reset mid-bubble
    step(1, I_RS1,  C_LU,   14, 2);
    step(1, I_RST,  C_RSTB, 15, 2);
    step(1, I_NONE, C_IDLE, 0, 0);

    @(posedge clk);
    #1;
    in_a = I_NONE;
    in_b = I_NONE;
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
